// File: rtl/mod_fp16_to_fixed.sv
// Iterative converter from the 16-bit float word {sign, exp[4:0], mant[9:0]} to signed
// fixed point Q(OUT_W-FRAC_W).FRAC_W, rounding to nearest (ties away) and saturating.
module mod_fp16_to_fixed #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 8,
   parameter int BIAS   = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      in_A,
   input  logic             in_En,
   output logic [OUT_W-1:0] out_Out,
   output logic             out_Ready,
   output logic             out_Busy,
   output logic             out_Sat
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, ROUND} state_t;

   localparam int MAG_W = OUT_W + 1;
   localparam logic signed [6:0] SH_OFF = 7'(BIAS + 10 - FRAC_W);
   localparam logic signed [6:0] SH_MIN = -7'sd12;
   localparam logic signed [6:0] SH_MAX = 7'(OUT_W - 11);
   localparam logic [MAG_W-1:0] POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
   localparam logic [MAG_W-1:0] NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [MAG_W-1:0] SAT_MAG = {MAG_W{1'b1}};

   state_t state, nextState;

   logic [15:0]       aReg;
   logic [MAG_W-1:0]  mag;
   logic              guard;
   logic              sticky;
   logic [3:0]        count;
   logic              dirLeft;

   logic signed [6:0] sh;
   logic [3:0]        shAbs;
   logic              isZero;
   logic              isTiny;
   logic              isOver;
   logic              signBit;
   logic [MAG_W-1:0]  magRnd;
   logic              clampPos;
   logic              clampNeg;

   always_comb begin
      signBit  = aReg[15];
      sh       = $signed({2'b00, aReg[14:10]}) - SH_OFF;
      shAbs    = sh[6] ? 4'(-sh) : 4'(sh);
      isZero   = (aReg[14:0] == 15'd0);
      isTiny   = (sh <= SH_MIN);
      isOver   = (sh > SH_MAX);
      magRnd   = mag + {{(MAG_W-1){1'b0}}, guard};
      clampPos = !signBit && (magRnd > POS_LIM);
      clampNeg = signBit && (magRnd > NEG_LIM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (in_En) nextState = SETUP;
         SETUP: begin
            if (isZero || isTiny || isOver || (shAbs == 4'd0)) nextState = ROUND;
            else                                               nextState = SHIFT;
         end
         SHIFT: if (count == 4'd1) nextState = ROUND;
         ROUND: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      out_Busy = (state != IDLE);
   end

   // Zero and saturate cases skip shifting by loading a magnitude the limit check already resolves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aReg      <= '0;
         mag       <= '0;
         guard     <= 1'b0;
         sticky    <= 1'b0;
         count     <= '0;
         dirLeft   <= 1'b0;
         out_Out   <= '0;
         out_Sat   <= 1'b0;
         out_Ready <= 1'b0;
      end else begin
         out_Ready <= 1'b0;
         case (state)
            IDLE: begin
               if (in_En) aReg <= in_A;
            end
            SETUP: begin
               guard  <= 1'b0;
               sticky <= 1'b0;
               if (isZero || isTiny) begin
                  mag   <= '0;
                  count <= '0;
               end else if (isOver) begin
                  mag   <= SAT_MAG;
                  count <= '0;
               end else begin
                  mag     <= {{(OUT_W-10){1'b0}}, 1'b1, aReg[9:0]};
                  count   <= shAbs;
                  dirLeft <= !sh[6];
               end
            end
            SHIFT: begin
               count <= count - 4'd1;
               if (dirLeft) begin
                  mag <= {mag[MAG_W-2:0], 1'b0};
               end else begin
                  mag    <= {1'b0, mag[MAG_W-1:1]};
                  guard  <= mag[0];
                  sticky <= sticky | guard;
               end
            end
            ROUND: begin
               out_Ready <= 1'b1;
               if (clampPos) begin
                  out_Out <= POS_LIM[OUT_W-1:0];
                  out_Sat <= 1'b1;
               end else if (clampNeg) begin
                  out_Out <= NEG_LIM[OUT_W-1:0];
                  out_Sat <= 1'b1;
               end else begin
                  out_Out <= signBit ? -magRnd[OUT_W-1:0] : magRnd[OUT_W-1:0];
                  out_Sat <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
